mem_etapa_param: RTL

- Parametrised successor of the MIPS MEM pipeline stage.
- Adds byte, halfword and word loads/stores with sign or zero extension, and misalignment detection.
- Adds a configurable multi-cycle read latency with a stall handshake toward EX, and a registered MEM/WB pipeline register.
- Sits between the EX/MEM register and the WB stage; feeds the register bank write port and the forwarding unit.

---
 rtl/mem_etapa_param.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_etapa_param.sv
// MIPS MEM stage: byte/half/word loads and stores with extension, misalignment
// detection, multi-cycle load latency with stall toward EX, and MEM/WB register.
module mem_etapa_param #(
  parameter int PROFUNDIDAD = 256,
  parameter int LAT_LECTURA = 1,
  parameter int ANCHO_REG   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reg_escribir_MEM,
  input  logic                 mem_a_reg_MEM,
  input  logic                 mem_escribir_MEM,
  input  logic                 mem_leer_MEM,
  input  logic [1:0]           tam_MEM,
  input  logic                 sin_signo_MEM,
  input  logic [31:0]          resultado_alu_MEM,
  input  logic [31:0]          dr2_forward_MEM,
  input  logic [ANCHO_REG-1:0] registro_destino_MEM,
  output logic [31:0]          write_data_WB,
  output logic [ANCHO_REG-1:0] rd_WB,
  output logic                 reg_write_WB,
  output logic                 error_alineacion_WB,
  output logic                 detener_MEM
);

  localparam int AW = $clog2(PROFUNDIDAD);
  localparam bit MULTICICLO = (LAT_LECTURA > 1);
  localparam logic [2:0] CNT_INI = 3'(LAT_LECTURA - 1);

  typedef enum logic {LIBRE, ESPERA} estado_t;

  estado_t     estado_reg;
  logic [2:0]  contador_reg;
  logic [31:0] mem [PROFUNDIDAD];

  logic [AW-1:0] indice;
  logic [1:0]    carril;
  logic          es_byte, es_half, es_word;
  logic          desalineado, carga_inicia, escritura;
  logic [3:0]    be;
  logic [31:0]   dato_st;
  logic [31:0]   palabra;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   carga_ext;
  logic [31:0]   write_data_next;

  assign indice  = resultado_alu_MEM[AW+1:2];
  assign carril  = resultado_alu_MEM[1:0];
  assign es_byte = (tam_MEM == 2'b00);
  assign es_half = (tam_MEM == 2'b01);
  assign es_word = tam_MEM[1];

  assign desalineado  = (mem_leer_MEM | mem_escribir_MEM) &
                        ((es_half & carril[0]) | (es_word & (carril != 2'b00)));
  assign carga_inicia = mem_leer_MEM & ~mem_escribir_MEM & ~desalineado;
  // Stores are only accepted in LIBRE; during ESPERA the held load owns the stage.
  assign escritura    = mem_escribir_MEM & ~desalineado & ~reset & (estado_reg == LIBRE);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_carril
      localparam logic [1:0] CARRIL = 2'(gi);
      assign be[gi] = es_word | (es_half & (carril[1] == CARRIL[1])) |
                      (es_byte & (carril == CARRIL));
      assign dato_st[8*gi +: 8] = es_byte ? dr2_forward_MEM[7:0] :
                                  es_half ? dr2_forward_MEM[8*(gi%2) +: 8] :
                                            dr2_forward_MEM[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (escritura) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[indice][8*b +: 8] <= dato_st[8*b +: 8];
      end
    end
  end

  // Asynchronous read so a load right after a store sees the new word.
  assign palabra  = mem[indice];
  assign byte_sel = palabra[8*carril +: 8];
  assign half_sel = carril[1] ? palabra[31:16] : palabra[15:0];

  always_comb begin
    carga_ext = palabra;
    if (es_byte)
      carga_ext = {{24{~sin_signo_MEM & byte_sel[7]}}, byte_sel};
    else if (es_half)
      carga_ext = {{16{~sin_signo_MEM & half_sel[15]}}, half_sel};
  end

  assign write_data_next = mem_a_reg_MEM ? carga_ext : resultado_alu_MEM;

  assign detener_MEM = ~reset &
                       (((estado_reg == LIBRE) & MULTICICLO & carga_inicia) |
                        ((estado_reg == ESPERA) & (contador_reg > 3'd1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_reg          <= LIBRE;
      contador_reg        <= 3'd0;
      write_data_WB       <= 32'd0;
      rd_WB               <= '0;
      reg_write_WB        <= 1'b0;
      error_alineacion_WB <= 1'b0;
    end else begin
      case (estado_reg)
        LIBRE: begin
          if (MULTICICLO && carga_inicia) begin
            estado_reg          <= ESPERA;
            contador_reg        <= CNT_INI;
            reg_write_WB        <= 1'b0;
            error_alineacion_WB <= 1'b0;
          end else begin
            write_data_WB       <= write_data_next;
            rd_WB               <= registro_destino_MEM;
            reg_write_WB        <= reg_escribir_MEM & ~desalineado;
            error_alineacion_WB <= desalineado;
          end
        end
        ESPERA: begin
          if (contador_reg > 3'd1) begin
            contador_reg        <= contador_reg - 3'd1;
            reg_write_WB        <= 1'b0;
            error_alineacion_WB <= 1'b0;
          end else begin
            estado_reg          <= LIBRE;
            contador_reg        <= 3'd0;
            write_data_WB       <= write_data_next;
            rd_WB               <= registro_destino_MEM;
            reg_write_WB        <= reg_escribir_MEM & ~desalineado;
            error_alineacion_WB <= desalineado;
          end
        end
        default: estado_reg <= LIBRE;
      endcase
    end
  end

endmodule
